// File: rtl/quad_pkg.sv
// Shared phase codes, direction encodings and the up-sequence successor
// function used by the quadrature decoder.
package quad_pkg;

  // Phase codes as {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Direction encodings for the ud output
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Successor of a phase in the up sequence 00->10->11->01->00
  function automatic logic [1:0] next_up(input logic [1:0] ab);
    logic [1:0] nxt;
    case (ab)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// 1-bit multi-flop synchronizer for an input asynchronous to clk.
// All flops clear to 0 on the asynchronous reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  // Shift the asynchronous input through STAGES flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff_q <= '0;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/quad_decoder_updown.sv
// Quadrature A/B decoder: synchronizes both phases, decodes each phase
// change into an up/down step or an illegal-transition error, and keeps a
// wrapping position count. All outputs are registered.
module quad_decoder_updown
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             ud,
  output logic             step,
  output logic             err
);

  // Priming waits until the synchronizer pipe has filled and prev_ab has
  // caught up with it, so the first decoded comparison is never stale.
  localparam logic [2:0] PRIME_N = 3'(SYNC_STAGES);

  logic             a_s;
  logic             b_s;
  logic [1:0]       ab_s;

  logic [1:0]       prev_ab_q;
  logic             primed_q,    primed_d;
  logic [2:0]       prime_cnt_q, prime_cnt_d;
  logic [WIDTH-1:0] count_q,     count_d;
  logic             ud_q,        ud_d;
  logic             step_q,      step_d;
  logic             err_q,       err_d;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
    .clk (clk),
    .rst (rst),
    .d_i (a_in),
    .q_o (a_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_b (
    .clk (clk),
    .rst (rst),
    .d_i (b_in),
    .q_o (b_s)
  );

  assign ab_s = {a_s, b_s};

  // Next-state: priming counter and per-cycle direction/error decode
  always_comb begin
    primed_d    = primed_q;
    prime_cnt_d = prime_cnt_q;
    count_d     = count_q;
    ud_d        = ud_q;
    step_d      = 1'b0;
    err_d       = 1'b0;

    if (!primed_q) begin
      if (prime_cnt_q == PRIME_N) begin
        primed_d = 1'b1;
      end else begin
        prime_cnt_d = prime_cnt_q + 3'd1;
      end
    end else if (en && (ab_s != prev_ab_q)) begin
      if (ab_s == next_up(prev_ab_q)) begin
        count_d = count_q + WIDTH'(1);
        ud_d    = DIR_UP;
        step_d  = 1'b1;
      end else if (prev_ab_q == next_up(ab_s)) begin
        count_d = count_q - WIDTH'(1);
        ud_d    = DIR_DN;
        step_d  = 1'b1;
      end else begin
        err_d   = 1'b1;
      end
    end
  end

  // State registers; prev_ab tracks the synchronized phase every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_ab_q   <= PH_00;
      primed_q    <= 1'b0;
      prime_cnt_q <= '0;
      count_q     <= '0;
      ud_q        <= DIR_UP;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_ab_q   <= ab_s;
      primed_q    <= primed_d;
      prime_cnt_q <= prime_cnt_d;
      count_q     <= count_d;
      ud_q        <= ud_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  assign count = count_q;
  assign ud    = ud_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule
